// File: rtl/reqack_pkg.sv
// Shared definitions for the four-producer req/ack round-robin arbiter:
// FSM state encoding, channel count, synchroniser depth and the
// round-robin winner selection.
package reqack_pkg;

  localparam int NPROD       = 4;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    C_REQ = 2'd1,
    C_REL = 2'd2,
    P_REL = 2'd3
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } pick_t;

  // Search order is last+1, last+2, last+3, last (mod 4). Walking the
  // offsets from farthest to nearest lets the nearest hit overwrite.
  function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] last);
    pick_t      p;
    logic [1:0] cand;
    p = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        p.vld = 1'b1;
        p.idx = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/reqack_sync2.sv
// Multi-flop level synchroniser for one asynchronous handshake bit.
module reqack_sync2
  import reqack_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p;

  // Shift the raw level through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_p <= '0;
    else     sync_p <= {sync_p[SYNC_STAGES-2:0], d};
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/reqack_arbiter_rr4.sv
// Four-producer, one-consumer round-robin arbiter for four-phase req/ack
// channels. All incoming handshake levels are resynchronised; one producer
// is granted per pass, its word captured and forwarded to the consumer.
module reqack_arbiter_rr4
  import reqack_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              prod_req,
  output logic [3:0]              prod_ack,
  input  logic [4*DWIDTH-1:0]     prod_dat,
  input  logic [3:0]              grant_mask,
  output logic                    cons_req,
  input  logic                    cons_ack,
  output logic [DWIDTH-1:0]       cons_dat,
  output logic [1:0]              cons_src,
  output logic                    busy
);

  logic [3:0] sreq;
  logic       scack;
  state_e     state;
  logic [1:0] last;
  logic [1:0] cur;
  logic [3:0] elig;
  pick_t      pick;

  for (genvar g = 0; g < NPROD; g++) begin : g_req_sync
    reqack_sync2 u_sync (.clk(clk), .rst(rst), .d(prod_req[g]), .q(sreq[g]));
  end

  reqack_sync2 u_ack_sync (.clk(clk), .rst(rst), .d(cons_ack), .q(scack));

  // The mask only gates new grants; an in-flight transaction is never aborted
  assign elig = sreq & grant_mask & ~prod_ack;
  assign pick = rr_pick(elig, last);

  // Handshake FSM: grant in IDLE, then consumer four-phase, then producer release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 2'd3;
      cur      <= 2'd0;
      prod_ack <= '0;
      cons_req <= 1'b0;
      cons_dat <= '0;
      cons_src <= 2'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick.vld) begin
            cons_dat           <= prod_dat[pick.idx*DWIDTH +: DWIDTH];
            cons_src           <= pick.idx;
            prod_ack[pick.idx] <= 1'b1;
            cons_req           <= 1'b1;
            cur                <= pick.idx;
            state              <= C_REQ;
            busy               <= 1'b1;
          end
        end
        C_REQ: begin
          if (scack) begin
            cons_req <= 1'b0;
            state    <= C_REL;
          end
        end
        C_REL: begin
          if (!scack) state <= P_REL;
        end
        P_REL: begin
          if (!sreq[cur]) begin
            prod_ack[cur] <= 1'b0;
            last          <= cur;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
